// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the LEGv8 control sequencer: control-word layout,
// field encodings, opcode match patterns and the instruction-class enum.
package control_sequencer_pkg;

   localparam int PSEL_W = 2;
   localparam int REG_W  = 5;
   localparam int FSEL_W = 5;
   localparam int DSEL_W = 2;

   // Bit offsets of each field inside the packed control word, LSB first.
   localparam int CW_SL_LSB    = 0;
   localparam int CW_PCSEL_LSB = CW_SL_LSB + 1;
   localparam int CW_BSEL_LSB  = CW_PCSEL_LSB + 1;
   localparam int CW_DSEL_LSB  = CW_BSEL_LSB + 1;
   localparam int CW_RAMW_LSB  = CW_DSEL_LSB + DSEL_W;
   localparam int CW_REGW_LSB  = CW_RAMW_LSB + 1;
   localparam int CW_FSEL_LSB  = CW_REGW_LSB + 1;
   localparam int CW_SB_LSB    = CW_FSEL_LSB + FSEL_W;
   localparam int CW_SA_LSB    = CW_SB_LSB + REG_W;
   localparam int CW_DA_LSB    = CW_SA_LSB + REG_W;
   localparam int CW_PSEL_LSB  = CW_DA_LSB + REG_W;
   localparam int CW_WIDTH     = CW_PSEL_LSB + PSEL_W;

   localparam logic [PSEL_W-1:0] PSEL_HOLD = 2'b00;
   localparam logic [PSEL_W-1:0] PSEL_PC4  = 2'b01;
   localparam logic [DSEL_W-1:0] DSEL_RAM  = 2'b00;
   localparam logic [DSEL_W-1:0] DSEL_ALU  = 2'b01;

   localparam logic [FSEL_W-1:0] FSEL_ADD     = 5'b01000;
   localparam logic [3:0]        FSEL_AS_HIGH = 4'b0100;

   localparam logic [6:0]  OP_IARITH = 7'b1000100;
   localparam logic [10:0] OP_LDUR   = 11'b11111000010;
   localparam logic [10:0] OP_STUR   = 11'b11111000000;

   localparam logic [1:0] STEP_FIRST = 2'd0;
   localparam logic [1:0] STEP_LDUR_WB = 2'd1;

   typedef enum logic [1:0] {
      CLS_NOP    = 2'd0,
      CLS_IARITH = 2'd1,
      CLS_LDUR   = 2'd2,
      CLS_STUR   = 2'd3
   } instrClass_e;

   typedef struct packed {
      logic [PSEL_W-1:0] psel;
      logic [REG_W-1:0]  da;
      logic [REG_W-1:0]  sa;
      logic [REG_W-1:0]  sb;
      logic [FSEL_W-1:0] fsel;
      logic              regW;
      logic              ramW;
      logic [DSEL_W-1:0] dsel;
      logic              bsel;
      logic              pcsel;
      logic              sl;
   } ctrlWord_t;

endpackage

// File: rtl/control_sequencer_instr_class_decode.sv
// Classifies the upper opcode bits of the held instruction into one of the
// sequencer's instruction classes; anything unrecognised becomes a NOP.
module instr_class_decode
   import control_sequencer_pkg::*;
(
   input  logic [10:0]  opField_i,
   output instrClass_e  class_o
);

   // opField_i carries IR[31:21], so IR[28:22] sits at opField_i[7:1].
   always_comb begin
      class_o = CLS_NOP;
      if (opField_i == OP_LDUR) begin
         class_o = CLS_LDUR;
      end else if (opField_i == OP_STUR) begin
         class_o = CLS_STUR;
      end else if (opField_i[7:1] == OP_IARITH) begin
         class_o = CLS_IARITH;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-step control sequencer: latches one LEGv8 instruction at a time and
// emits one control word per micro-step under a valid/ready handshake.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [31:0]         instr_in,
   input  logic                instr_valid,
   output logic                instr_ready,
   output logic                cw_valid,
   input  logic                cw_ready,
   output logic [CW_WIDTH-1:0] controlWord,
   output logic [63:0]         K,
   output logic [1:0]          state
);

   logic [31:0] ir_q, ir_d;
   logic [1:0]  state_q, state_d;
   logic        cwValid_q, cwValid_d;

   instrClass_e irClass;
   instrClass_e stepClass;
   ctrlWord_t   cwFields;
   logic [63:0] kValue;
   logic        finalStep;
   logic        accept;
   logic        consume;

   instr_class_decode uClassDecode (
      .opField_i (ir_q[31:21]),
      .class_o   (irClass)
   );

   // Only LDUR legitimately reaches step 1; any other step value is retired as a NOP.
   always_comb begin
      stepClass = CLS_NOP;
      if (state_q == STEP_FIRST) begin
         stepClass = irClass;
      end else if (state_q == STEP_LDUR_WB && irClass == CLS_LDUR) begin
         stepClass = CLS_LDUR;
      end
   end

   assign finalStep   = !(stepClass == CLS_LDUR && state_q == STEP_FIRST);
   assign instr_ready = !cwValid_q | (cw_ready & finalStep);
   assign accept      = instr_valid & instr_ready;
   assign consume     = cwValid_q & cw_ready;

   // A new accept wins over retiring the current word, which gives back-to-back issue.
   always_comb begin
      ir_d      = ir_q;
      state_d   = state_q;
      cwValid_d = cwValid_q;
      if (accept) begin
         ir_d      = instr_in;
         state_d   = STEP_FIRST;
         cwValid_d = 1'b1;
      end else if (consume) begin
         if (finalStep) begin
            cwValid_d = 1'b0;
            state_d   = STEP_FIRST;
         end else begin
            state_d   = STEP_LDUR_WB;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir_q      <= '0;
         state_q   <= STEP_FIRST;
         cwValid_q <= 1'b0;
      end else begin
         ir_q      <= ir_d;
         state_q   <= state_d;
         cwValid_q <= cwValid_d;
      end
   end

   // Control word is decoded purely from the held IR and step, and forced to zero while idle.
   always_comb begin
      cwFields = '0;
      kValue   = '0;
      if (cwValid_q) begin
         case (stepClass)
            CLS_IARITH: begin
               cwFields.psel = PSEL_PC4;
               cwFields.da   = ir_q[4:0];
               cwFields.sa   = ir_q[9:5];
               cwFields.fsel = {FSEL_AS_HIGH, ir_q[30]};
               cwFields.regW = 1'b1;
               cwFields.dsel = DSEL_ALU;
               cwFields.bsel = 1'b1;
               cwFields.sl   = ir_q[29];
               kValue        = {52'd0, ir_q[21:10]};
            end
            CLS_LDUR: begin
               cwFields.psel = (state_q == STEP_FIRST) ? PSEL_HOLD : PSEL_PC4;
               cwFields.da   = ir_q[4:0];
               cwFields.sa   = ir_q[9:5];
               cwFields.fsel = FSEL_ADD;
               cwFields.regW = (state_q != STEP_FIRST);
               cwFields.dsel = (state_q == STEP_FIRST) ? DSEL_ALU : DSEL_RAM;
               cwFields.bsel = 1'b1;
               kValue        = {55'd0, ir_q[20:12]};
            end
            CLS_STUR: begin
               cwFields.psel = PSEL_PC4;
               cwFields.sa   = ir_q[9:5];
               cwFields.sb   = ir_q[4:0];
               cwFields.fsel = FSEL_ADD;
               cwFields.ramW = 1'b1;
               cwFields.dsel = DSEL_ALU;
               cwFields.bsel = 1'b1;
               kValue        = {55'd0, ir_q[20:12]};
            end
            default: begin
               cwFields.psel = PSEL_PC4;
            end
         endcase
      end
   end

   assign controlWord = cwFields;
   assign K           = kValue;
   assign state       = state_q;
   assign cw_valid    = cwValid_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus light random bench for control_sequencer; a queue of expected
// control words is filled on each modelled accept and drained on each consume.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic        cw_valid;
   logic        cw_ready;
   logic [28:0] controlWord;
   logic [63:0] K;
   logic [1:0]  state;

   typedef struct packed {
      logic [28:0] cw;
      logic [63:0] k;
      logic [1:0]  st;
      logic        last;
   } expWord_t;

   expWord_t expQ[$];
   int total = 0;
   int bad = 0;

   localparam logic [31:0] ADDI   = 32'h91001441;
   localparam logic [31:0] LDUR   = 32'hF8408083;
   localparam logic [31:0] STUR   = 32'hF8010045;
   localparam logic [31:0] SUBIS  = {3'b111, 7'b1000100, 12'hFFF, 5'd8, 5'd7};
   localparam logic [31:0] LDURMX = {11'b11111000010, 9'h1FF, 2'b11, 5'd31, 5'd31};
   localparam logic [28:0] ADDI_CW = 29'b01_00001_00010_00000_01000_1_0_01_1_0_0;

   control_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .cw_valid    (cw_valid),
      .cw_ready    (cw_ready),
      .controlWord (controlWord),
      .K           (K),
      .state       (state)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference behaviour: every step an instruction should produce, in order.
   task automatic pushModel(input logic [31:0] i);
      expWord_t e;
      e = '0;
      if (i[31:21] == 11'b11111000010) begin
         e.cw   = {2'b00, i[4:0], i[9:5], 5'd0, 5'b01000, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
         e.k    = {55'd0, i[20:12]};
         e.st   = 2'd0;
         e.last = 1'b0;
         expQ.push_back(e);
         e.cw   = {2'b01, i[4:0], i[9:5], 5'd0, 5'b01000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0};
         e.st   = 2'd1;
         e.last = 1'b1;
         expQ.push_back(e);
      end else if (i[31:21] == 11'b11111000000) begin
         e.cw   = {2'b01, 5'd0, i[9:5], i[4:0], 5'b01000, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
         e.k    = {55'd0, i[20:12]};
         e.last = 1'b1;
         expQ.push_back(e);
      end else if (i[28:22] == 7'b1000100) begin
         e.cw   = {2'b01, i[4:0], i[9:5], 5'd0, 4'b0100, i[30], 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, i[29]};
         e.k    = {52'd0, i[21:10]};
         e.last = 1'b1;
         expQ.push_back(e);
      end else begin
         e.cw   = {2'b01, 27'd0};
         e.last = 1'b1;
         expQ.push_back(e);
      end
   endtask

   task automatic checkOutput(input logic ready, output logic expReady);
      expReady = (expQ.size() == 0) || (ready && expQ[0].last);
      checkValue("instr_ready", instr_ready, expReady);
      if (expQ.size() != 0) begin
         checkValue("cw_valid", cw_valid, 1'b1);
         checkValue("controlWord", controlWord, expQ[0].cw);
         checkValue("K", K, expQ[0].k);
         checkValue("state", state, expQ[0].st);
      end else begin
         checkValue("idleValid", cw_valid, 1'b0);
         checkValue("idleCw", controlWord, 29'd0);
         checkValue("idleK", K, 64'd0);
         checkValue("idleState", state, 2'd0);
      end
   endtask

   // One clock cycle: drive inputs, check current outputs, advance the model.
   task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic ready, input logic rst);
      logic expReady;
      @(negedge clock);
      instr_in    = instr;
      instr_valid = valid;
      cw_ready    = ready;
      reset       = rst;
      #1;
      checkOutput(ready, expReady);
      if (rst) begin
         expQ.delete();
      end else begin
         if (expQ.size() != 0 && ready) void'(expQ.pop_front());
         if (valid && expReady) pushModel(instr);
      end
   endtask

   initial begin
      logic [31:0] pool [6];
      logic [31:0] pick;
      pool = '{ADDI, LDUR, STUR, SUBIS, LDURMX, 32'h00000000};
      reset = 1'b1;
      instr_in = '0;
      instr_valid = 1'b0;
      cw_ready = 1'b0;
      repeat (2) @(posedge clock);

      $display("[TB] reset state");
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] ADDI single step");
      applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("addiCw", controlWord, ADDI_CW);
      checkValue("addiK", K, 64'd5);
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] LDUR two steps");
      applyStimulus(LDUR, 1'b1, 1'b1, 1'b0);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("ldurPsel0", controlWord[28:27], 2'b00);
      checkValue("ldurReady0", instr_ready, 1'b0);
      checkValue("ldurK", K, 64'd8);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("ldurPsel1", controlWord[28:27], 2'b01);
      checkValue("ldurRegW1", controlWord[6], 1'b1);
      checkValue("ldurDsel1", controlWord[4:3], 2'b00);
      checkValue("ldurReady1", instr_ready, 1'b1);
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] stall then back-to-back accept");
      applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
      repeat (3) applyStimulus(STUR, 1'b1, 1'b0, 1'b0);
      applyStimulus(STUR, 1'b1, 1'b1, 1'b0);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("sturRamW", controlWord[5], 1'b1);

      $display("[TB] unknown opcode and immediate extremes");
      applyStimulus(32'h00000000, 1'b1, 1'b1, 1'b0);
      applyStimulus(SUBIS, 1'b1, 1'b1, 1'b0);
      checkValue("nopCw", controlWord, {2'b01, 27'd0});
      applyStimulus(LDURMX, 1'b1, 1'b1, 1'b0);
      checkValue("subisK", K, 64'hFFF);
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
      applyStimulus(ADDI, 1'b1, 1'b1, 1'b0);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);

      $display("[TB] reset during LDUR step 1");
      applyStimulus(LDUR, 1'b1, 1'b1, 1'b0);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(ADDI, 1'b1, 1'b1, 1'b1);
      applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("rstCw", controlWord, 29'd0);
      checkValue("rstValid", cw_valid, 1'b0);

      $display("[TB] random traffic");
      for (int n = 0; n < 80; n++) begin
         pick = pool[$urandom_range(0, 5)];
         if ($urandom_range(0, 4) == 0) pick = $urandom;
         applyStimulus(pick, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
      end
      repeat (6) applyStimulus(32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("drained", 64'(expQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
